// File: rtl/cg_pass_scheduler.sv
// rtl/cg_pass_scheduler.sv - layer-level pass scheduler and psum drain sequencer for NUM_CG cluster groups
module cg_pass_scheduler #(
  parameter int NUM_CG = 4,
  parameter int SEL_W  = 2,
  parameter int PASS_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] num_pass,
  input  logic [LEN_W-1:0]  psum_rd_len,
  input  logic [NUM_CG-1:0] cg_idle,
  input  logic [NUM_CG-1:0] cg_cal_fin,
  output logic [NUM_CG-1:0] cg_en,
  output logic [NUM_CG-1:0] read_psum_en,
  output logic [SEL_W-1:0]  psum_sel,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              layer_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_CAL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0]  num_pass_q, num_pass_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [NUM_CG-1:0]  fin_seen_q, fin_seen_d;
  // zero_done_q carries the completion pulse of a zero-pass layer, which never leaves IDLE
  logic               zero_done_q, zero_done_d;

  logic               all_idle;
  logic [NUM_CG-1:0]  fin_now;

  // State and counter registers; reset returns everything to the idle values at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pass_cnt_q  <= '0;
      num_pass_q  <= '0;
      len_q       <= '0;
      sel_q       <= '0;
      beat_q      <= '0;
      fin_seen_q  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_cnt_q  <= pass_cnt_d;
      num_pass_q  <= num_pass_d;
      len_q       <= len_d;
      sel_q       <= sel_d;
      beat_q      <= beat_d;
      fin_seen_q  <= fin_seen_d;
      zero_done_q <= zero_done_d;
    end
  end

  // Next-state and output decode; abort overrides every transition and gates the enables
  always_comb begin
    state_d        = state_q;
    pass_cnt_d     = pass_cnt_q;
    num_pass_d     = num_pass_q;
    len_d          = len_q;
    sel_d          = sel_q;
    beat_d         = beat_q;
    fin_seen_d     = fin_seen_q;
    zero_done_d    = 1'b0;
    cg_en          = '0;
    read_psum_en   = '0;
    psum_out_valid = 1'b0;
    layer_done     = 1'b0;

    all_idle = &cg_idle;
    // A group whose cal_fin and idle rise together still counts as finished this cycle
    fin_now  = fin_seen_q | cg_cal_fin;

    case (state_q)
      S_IDLE: begin
        layer_done = zero_done_q;
        if (start) begin
          if (num_pass != '0) begin
            num_pass_d = num_pass;
            len_d      = psum_rd_len;
            pass_cnt_d = '0;
            sel_d      = '0;
            beat_d     = '0;
            state_d    = S_LAUNCH;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (all_idle) begin
          cg_en      = '1;
          fin_seen_d = '0;
          state_d    = S_WAIT_CAL;
        end
      end
      S_WAIT_CAL: begin
        fin_seen_d = fin_now;
        if ((&fin_now) && all_idle) begin
          if (pass_cnt_q == num_pass_q - PASS_W'(1)) begin
            sel_d   = '0;
            beat_d  = '0;
            state_d = (len_q == '0) ? S_DONE : S_DRAIN;
          end else begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            state_d    = S_LAUNCH;
          end
        end
      end
      S_DRAIN: begin
        psum_out_valid      = 1'b1;
        read_psum_en[sel_q] = psum_out_ready;
        if (psum_out_ready) begin
          if (beat_q + LEN_W'(1) == len_q) begin
            beat_d = '0;
            if (sel_q == SEL_W'(NUM_CG - 1)) begin
              state_d = S_DONE;
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        layer_done = 1'b1;
        pass_cnt_d = '0;
        sel_d      = '0;
        beat_d     = '0;
        fin_seen_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      pass_cnt_d   = '0;
      sel_d        = '0;
      beat_d       = '0;
      fin_seen_d   = '0;
      zero_done_d  = 1'b0;
      cg_en        = '0;
      read_psum_en = '0;
      layer_done   = 1'b0;
    end
  end

  assign psum_sel = sel_q;
  assign pass_cnt = pass_cnt_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cg_pass_scheduler.sv
// tb/tb_cg_pass_scheduler.sv - directed self-checking bench for cg_pass_scheduler
module tb_cg_pass_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] num_pass;
  logic [7:0] psum_rd_len;
  logic [3:0] cg_idle;
  logic [3:0] cg_cal_fin;
  logic [3:0] cg_en;
  logic [3:0] read_psum_en;
  logic [1:0] psum_sel;
  logic       psum_out_valid;
  logic       psum_out_ready;
  logic [7:0] pass_cnt;
  logic       busy;
  logic       layer_done;

  int n_chk  = 0;
  int n_fail = 0;

  cg_pass_scheduler #(
    .NUM_CG(4),
    .SEL_W (2),
    .PASS_W(8),
    .LEN_W (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .num_pass      (num_pass),
    .psum_rd_len   (psum_rd_len),
    .cg_idle       (cg_idle),
    .cg_cal_fin    (cg_cal_fin),
    .cg_en         (cg_en),
    .read_psum_en  (read_psum_en),
    .psum_sel      (psum_sel),
    .psum_out_valid(psum_out_valid),
    .psum_out_ready(psum_out_ready),
    .pass_cnt      (pass_cnt),
    .busy          (busy),
    .layer_done    (layer_done)
  );

  always #5 clock = ~clock;

  // Group model: after cg_en a group runs dly cycles, holds cal_fin for 2 cycles, then is idle
  int unsigned t[4];
  int unsigned dly[4];

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)             t[i] <= 0;
      else if (cg_en[i])     t[i] <= dly[i] + 2;
      else if (t[i] != 0)    t[i] <= t[i] - 1;
    end
  end

  always_comb begin
    cg_idle    = '0;
    cg_cal_fin = '0;
    for (int i = 0; i < 4; i++) begin
      cg_idle[i]    = (t[i] == 0);
      cg_cal_fin[i] = (t[i] != 0) && (t[i] <= 2);
    end
  end

  // Event monitor: cumulative counts and logs of launches, beats and completions
  int cyc = 0;
  int n_en = 0, n_beat = 0, n_rd = 0, n_rd_bad = 0, n_done = 0;
  int en_cyc[$];
  int en_pass[$];
  int sel_log[$];
  int done_cyc[$];
  logic [3:0] exp_rd;

  always @(posedge clock) begin
    if (!reset) begin
      cyc++;
      if (cg_en != 4'h0) begin
        n_en++;
        en_cyc.push_back(cyc);
        en_pass.push_back(int'(pass_cnt));
      end
      if (psum_out_valid && psum_out_ready) begin
        n_beat++;
        sel_log.push_back(int'(psum_sel));
      end
      if (read_psum_en != 4'h0) n_rd++;
      exp_rd = (psum_out_valid && psum_out_ready && !abort) ? (4'b0001 << psum_sel) : 4'b0000;
      if (read_psum_en !== exp_rd) n_rd_bad++;
      if (layer_done) begin
        n_done++;
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'b0, cg_en, read_psum_en, psum_sel, psum_out_valid, pass_cnt, busy, layer_done};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic launch(input logic [7:0] np, input logic [7:0] len);
    num_pass    = np;
    psum_rd_len = len;
    start       = 1'b1;
    @(negedge clock);
    start       = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle, input string tag);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      if (toggle && psum_out_valid) psum_out_ready = ~psum_out_ready;
      @(negedge clock);
      k++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  int b_en, b_beat, b_rd, b_rdbad, b_done, b_cyc, bad;

  task automatic snap();
    b_en    = n_en;
    b_beat  = n_beat;
    b_rd    = n_rd;
    b_rdbad = n_rd_bad;
    b_done  = n_done;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    num_pass       = 8'd0;
    psum_rd_len    = 8'd0;
    psum_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dly[i] = 0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("reset_outputs", outs(), 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);

    // Nominal layer: 3 passes, 4 beats per group
    snap();
    launch(8'd3, 8'd4);
    check("t1_first_cg_en", {28'b0, cg_en}, 32'h0000000F);
    check("t1_busy", {31'b0, busy}, 32'd1);
    wait_idle(1'b0, "t1_timeout");
    check("t1_cg_en_count", n_en - b_en, 32'd3);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (b_en + i >= en_pass.size() || en_pass[b_en + i] != i) bad++;
    check("t1_pass_seq", bad, 32'd0);
    check("t1_launch_gap", (en_cyc.size() >= b_en + 3) ? en_cyc[b_en + 2] - en_cyc[b_en] : -1, 32'd8);
    check("t1_beats", n_beat - b_beat, 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (b_beat + i >= sel_log.size() || sel_log[b_beat + i] != i / 4) bad++;
    check("t1_sel_seq", bad, 32'd0);
    check("t1_done_count", n_done - b_done, 32'd1);
    check("t1_done_latency", (done_cyc.size() > 0 && en_cyc.size() > b_en) ?
          done_cyc[done_cyc.size() - 1] - en_cyc[b_en] : -1, 32'd28);
    check("t1_idle_outputs", outs(), 32'd0);

    // Straggler: group 2 finishes 10 cycles after the others
    dly[2] = 10;
    snap();
    launch(8'd2, 8'd1);
    wait_idle(1'b0, "t2_timeout");
    dly[2] = 0;
    check("t2_cg_en_count", n_en - b_en, 32'd2);
    check("t2_launch_gap", (en_cyc.size() >= b_en + 2) ? en_cyc[b_en + 1] - en_cyc[b_en] : -1, 32'd14);
    check("t2_second_pass", (en_pass.size() >= b_en + 2) ? en_pass[b_en + 1] : -1, 32'd1);
    check("t2_beats", n_beat - b_beat, 32'd4);
    check("t2_done_count", n_done - b_done, 32'd1);

    // Backpressure: ready alternates during the drain
    snap();
    launch(8'd1, 8'd2);
    wait_idle(1'b1, "t3_timeout");
    psum_out_ready = 1'b1;
    check("t3_beats", n_beat - b_beat, 32'd8);
    check("t3_rd_cycles", n_rd - b_rd, 32'd8);
    check("t3_rd_gating", n_rd_bad - b_rdbad, 32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (b_beat + i >= sel_log.size() || sel_log[b_beat + i] != i / 2) bad++;
    check("t3_sel_seq", bad, 32'd0);
    check("t3_done_count", n_done - b_done, 32'd1);

    // Zero passes: immediate completion pulse, no launch
    snap();
    launch(8'd0, 8'd5);
    check("t4a_done_pulse", {31'b0, layer_done}, 32'd1);
    check("t4a_not_busy", {31'b0, busy}, 32'd0);
    tick(1);
    check("t4a_done_single", {31'b0, layer_done}, 32'd0);
    tick(3);
    check("t4a_no_cg_en", n_en - b_en, 32'd0);
    check("t4a_done_count", n_done - b_done, 32'd1);

    // One pass, zero drain length: drain skipped
    snap();
    launch(8'd1, 8'd0);
    wait_idle(1'b0, "t4b_timeout");
    check("t4b_cg_en_count", n_en - b_en, 32'd1);
    check("t4b_no_read", n_rd - b_rd, 32'd0);
    check("t4b_no_beats", n_beat - b_beat, 32'd0);
    check("t4b_done_count", n_done - b_done, 32'd1);

    // Abort in DRAIN at psum_sel=1, beat counter 2
    launch(8'd1, 8'd4);
    begin
      int k;
      k = 0;
      while (psum_sel != 2'd1 && k < 200) begin
        @(negedge clock);
        k++;
      end
    end
    check("t5_reach_sel1", {30'b0, psum_sel}, 32'd1);
    tick(2);
    snap();
    abort = 1'b1;
    #1;
    check("t5_abort_rd_gate", {28'b0, read_psum_en}, 32'd0);
    tick(1);
    abort = 1'b0;
    check("t5_after_abort", outs(), 32'd0);
    tick(3);
    check("t5_no_done", n_done - b_done, 32'd0);
    snap();
    launch(8'd2, 8'd1);
    wait_idle(1'b0, "t5_clean_timeout");
    check("t5_clean_cg_en", n_en - b_en, 32'd2);
    check("t5_clean_beats", n_beat - b_beat, 32'd4);
    check("t5_clean_done", n_done - b_done, 32'd1);

    // Async reset mid-WAIT_CAL
    for (int i = 0; i < 4; i++) dly[i] = 10;
    launch(8'd2, 8'd1);
    tick(4);
    check("t6_busy_before", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_outputs", outs(), 32'd0);
    start    = 1'b1;
    num_pass = 8'd2;
    tick(2);
    check("t6_start_ignored", {31'b0, busy}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) dly[i] = 0;
    reset = 1'b0;
    tick(1);
    check("t6_released", outs(), 32'd0);
    snap();
    launch(8'd1, 8'd1);
    check("t6_first_launch", {28'b0, cg_en}, 32'h0000000F);
    check("t6_pass0", {24'b0, pass_cnt}, 32'd0);
    wait_idle(1'b0, "t6_timeout");
    check("t6_done_count", n_done - b_done, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
